// File: rtl/fizzbuzz_stream.sv
// FizzBuzz listing generator: walks n = 1..LAST and streams the text as ASCII
// bytes over a valid/ready handshake, one 0x0A-terminated line per number.
module fizzbuzz_stream #(
  parameter int LAST = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  if (LAST < 1 || LAST > 255) begin : g_last_check
    $error("fizzbuzz_stream: LAST must be in 1..255");
  end

  localparam logic [7:0] LAST_N = 8'(LAST);

  typedef enum logic [1:0] {IDLE, WORD, DIGIT, NL} state_t;

  state_t      state;
  logic [7:0]  n;
  logic [1:0]  r3;
  logic [2:0]  r5;
  logic [11:0] bcd;
  logic [2:0]  idx;

  logic        fire;
  logic        fizz;
  logic        buzz;
  logic [2:0]  word_end;
  logic [1:0]  r3_inc;
  logic [2:0]  r5_inc;
  logic [11:0] bcd_inc;
  logic        inc_fizz;
  logic        inc_buzz;
  logic [2:0]  inc_idx;
  logic [7:0]  inc_byte;

  // "FizzBuzz" is "Fizz" followed by "Buzz", so positions 4..7 always read as Buzz.
  function automatic logic [7:0] word_char(input logic fz, input logic [2:0] i);
    logic use_fizz;
    use_fizz = fz & ~i[2];
    case (i[1:0])
      2'd0:    word_char = use_fizz ? 8'h46 : 8'h42;
      2'd1:    word_char = use_fizz ? 8'h69 : 8'h75;
      default: word_char = 8'h7A;
    endcase
  endfunction

  function automatic logic [7:0] digit_char(input logic [11:0] b, input logic [1:0] i);
    case (i)
      2'd0:    digit_char = {4'h3, b[11:8]};
      2'd1:    digit_char = {4'h3, b[7:4]};
      default: digit_char = {4'h3, b[3:0]};
    endcase
  endfunction

  always_comb begin
    fire     = out_valid & out_ready;
    fizz     = (r3 == 2'd0);
    buzz     = (r5 == 3'd0);
    word_end = (fizz && buzz) ? 3'd7 : 3'd3;
    r3_inc   = (r3 == 2'd2) ? 2'd0 : r3 + 2'd1;
    r5_inc   = (r5 == 3'd4) ? 3'd0 : r5 + 3'd1;

    bcd_inc = bcd;
    if (bcd[3:0] != 4'd9) begin
      bcd_inc[3:0] = bcd[3:0] + 4'd1;
    end else begin
      bcd_inc[3:0] = '0;
      if (bcd[7:4] != 4'd9) begin
        bcd_inc[7:4] = bcd[7:4] + 4'd1;
      end else begin
        bcd_inc[7:4]  = '0;
        bcd_inc[11:8] = bcd[11:8] + 4'd1;
      end
    end

    // First byte of the following line, so it is registered without a bubble.
    inc_fizz = (r3_inc == 2'd0);
    inc_buzz = (r5_inc == 3'd0);
    if (bcd_inc[11:8] != 4'd0)     inc_idx = 3'd0;
    else if (bcd_inc[7:4] != 4'd0) inc_idx = 3'd1;
    else                           inc_idx = 3'd2;
    inc_byte = (inc_fizz || inc_buzz) ? word_char(inc_fizz, 3'd0)
                                      : digit_char(bcd_inc, inc_idx[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      r3        <= '0;
      r5        <= '0;
      bcd       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // n = 1 is never Fizz/Buzz, so the run always opens on the digit '1'.
            n         <= 8'd1;
            r3        <= 2'd1;
            r5        <= 3'd1;
            bcd       <= 12'h001;
            idx       <= 3'd2;
            state     <= DIGIT;
            out_data  <= 8'h31;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WORD: begin
          if (fire) begin
            if (idx == word_end) begin
              state    <= NL;
              out_data <= 8'h0A;
              out_last <= (n == LAST_N);
            end else begin
              idx      <= idx + 3'd1;
              out_data <= word_char(fizz, idx + 3'd1);
            end
          end
        end
        DIGIT: begin
          if (fire) begin
            if (idx == 3'd2) begin
              state    <= NL;
              out_data <= 8'h0A;
              out_last <= (n == LAST_N);
            end else begin
              idx      <= idx + 3'd1;
              out_data <= digit_char(bcd, idx[1:0] + 2'd1);
            end
          end
        end
        NL: begin
          if (fire) begin
            if (out_last) begin
              state     <= IDLE;
              out_data  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              n        <= n + 8'd1;
              r3       <= r3_inc;
              r5       <= r5_inc;
              bcd      <= bcd_inc;
              state    <= (inc_fizz || inc_buzz) ? WORD : DIGIT;
              idx      <= (inc_fizz || inc_buzz) ? 3'd0 : inc_idx;
              out_data <= inc_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
